// File: rtl/accel_job_dispatcher.sv
// Host-side initiator for the iterative accelerator: issues one start/ready handshake per operand
// and queues each result (or a timeout error tag) in a first-word fall-through FIFO.
module accel_job_dispatcher #(
  parameter int DW      = 16,
  parameter int RW      = 16,
  parameter int DEPTH   = 4,
  parameter int BUSY_TO = 4,
  parameter int DONE_TO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          acc_ready,
  input  logic [RW-1:0] acc_result,
  output logic          acc_start,
  output logic [DW-1:0] acc_x,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  output logic          out_err,
  input  logic          out_ready,
  output logic          busy,
  output logic [7:0]    job_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (DONE_TO > BUSY_TO) ? DONE_TO : BUSY_TO;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, ARM, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          accept, pop, push, push_err;
  logic [RW-1:0] push_data;

  logic [RW-1:0] mem_data [DEPTH];
  logic          mem_err  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;

  // Only one job is ever in flight, so gating acceptance on a free slot guarantees room for its push.
  assign in_ready  = (state == IDLE) && (fifo_count < CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_err   = out_valid ? mem_err[rd_ptr]  : 1'b0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    push      = 1'b0;
    push_err  = 1'b0;
    push_data = '0;
    case (state)
      IDLE:  if (accept) state_nxt = ARM;
      ARM:   if (acc_ready) state_nxt = START;
      START: begin
        timer_nxt = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!acc_ready) begin
          timer_nxt = '0;
          state_nxt = WAIT_DONE;
        end else if (timer == TW'(BUSY_TO - 1)) begin
          push      = 1'b1;
          push_err  = 1'b1;
          timer_nxt = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (acc_ready) begin
          push      = 1'b1;
          push_data = acc_result;
          timer_nxt = '0;
          state_nxt = IDLE;
        end else if (timer == TW'(DONE_TO - 1)) begin
          push      = 1'b1;
          push_err  = 1'b1;
          timer_nxt = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // acc_start is high only while in START, so it can never stay up for two cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      acc_start <= 1'b0;
      acc_x     <= '0;
      job_count <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      acc_start <= (state_nxt == START);
      if (accept) acc_x <= in_data;
      if (push) job_count <= job_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_err[wr_ptr]  <= push_err;
    end
  end

endmodule

// File: tb/tb_accel_job_dispatcher.sv
// Directed bench for accel_job_dispatcher with a small behavioural accelerator responder.
module tb_accel_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        acc_ready;
  logic [15:0] acc_result;
  logic        acc_start;
  logic [15:0] acc_x;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_err;
  logic        out_ready;
  logic        busy;
  logic [7:0]  job_count;

  int tests = 0;
  int fails = 0;

  // Responder controls: mode 0 = normal, 1 = never goes busy, 2 = busy forever once started.
  int          mode;
  int          lat;
  logic [15:0] key;
  logic        hold_low;
  logic        m_ready;
  int          m_cnt;

  int start_cnt    = 0;
  int double_start = 0;
  logic prev_start = 1'b0;

  accel_job_dispatcher #(.DW(16), .RW(16), .DEPTH(4), .BUSY_TO(4), .DONE_TO(255)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .acc_ready(acc_ready), .acc_result(acc_result), .acc_start(acc_start), .acc_x(acc_x),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err), .out_ready(out_ready),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  assign acc_ready = m_ready && !hold_low;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready    <= 1'b1;
      m_cnt      <= 0;
      acc_result <= 16'h0000;
    end else if (m_ready && acc_start && mode != 1) begin
      m_ready <= 1'b0;
      m_cnt   <= 0;
    end else if (!m_ready && mode != 2) begin
      if (m_cnt >= lat - 1) begin
        m_ready    <= 1'b1;
        acc_result <= acc_x ^ key;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (acc_start) start_cnt = start_cnt + 1;
    if (acc_start && prev_start) double_start = double_start + 1;
    prev_start = acc_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    int n = 0;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    chk("send_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (!out_valid && n < maxc) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(out_valid), 1);
  endtask

  task automatic wait_jobs(input logic [7:0] target, input int maxc);
    int n = 0;
    while (job_count != target && n < maxc) begin
      tick();
      n++;
    end
    chk("wait_jobs", 32'(job_count), 32'(target));
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int s0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mode = 0; lat = 10; key = 16'h0000; hold_low = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_acc_start", 32'(acc_start), 0);
    chk("rst_acc_x", 32'(acc_x), 0);
    chk("rst_job_count", 32'(job_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    #10 rst = 1'b0;
    tick();
    chk("rel_in_ready", 32'(in_ready), 1);

    // Single job
    key = 16'h1237;
    s0 = start_cnt;
    send(16'h0003);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_acc_x", 32'(acc_x), 32'h0003);
    chk("t1_in_ready", 32'(in_ready), 0);
    tick();
    chk("t1_start_cycle2", 32'(acc_start), 1);
    tick();
    chk("t1_start_drop", 32'(acc_start), 0);
    wait_valid(40, n);
    chk("t1_data", 32'(out_data), 32'h1234);
    chk("t1_err", 32'(out_err), 0);
    chk("t1_jobs", 32'(job_count), 1);
    chk("t1_starts", 32'(start_cnt - s0), 1);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_acc_x_held", 32'(acc_x), 32'h0003);
    pop1();
    chk("t1_popped", 32'(out_valid), 0);

    // Back-to-back fill of the FIFO
    lat = 3; key = 16'hA5A5;
    for (int i = 0; i < 4; i++) send(16'(16'h0010 + i));
    wait_jobs(8'd5, 100);
    chk("t2_full_in_ready", 32'(in_ready), 0);
    chk("t2_head0", 32'(out_data), 32'hA5B5);
    in_valid = 1'b1; in_data = 16'h0099;
    tick();
    chk("t2_no_accept_full", 32'(busy), 0);
    in_valid = 1'b0;
    pop1();
    chk("t2_reenable", 32'(in_ready), 1);
    chk("t2_head1", 32'(out_data), 32'hA5B4);
    pop1();
    chk("t2_head2", 32'(out_data), 32'hA5B7);
    pop1();
    chk("t2_head3", 32'(out_data), 32'hA5B6);
    pop1();
    chk("t2_empty", 32'(out_valid), 0);
    pop1();
    chk("t2_empty_pop", 32'(out_valid), 0);
    chk("t2_jobs", 32'(job_count), 5);

    // Accelerator never drops ready
    mode = 1;
    send(16'h0055);
    wait_valid(30, n);
    chk("t3_latency", 32'(n), 6);
    chk("t3_err", 32'(out_err), 1);
    chk("t3_data", 32'(out_data), 0);
    chk("t3_idle", 32'(busy), 0);
    chk("t3_jobs", 32'(job_count), 6);
    pop1();

    // Accelerator never finishes, then recovers
    mode = 2;
    send(16'h0077);
    wait_valid(400, n);
    chk("t4_latency", 32'(n), 258);
    chk("t4_err", 32'(out_err), 1);
    chk("t4_data", 32'(out_data), 0);
    chk("t4_jobs", 32'(job_count), 7);
    mode = 0;
    pop1();
    send(16'h0021);
    wait_valid(60, n);
    chk("t4_next_data", 32'(out_data), 32'hA584);
    chk("t4_next_err", 32'(out_err), 0);
    chk("t4_next_jobs", 32'(job_count), 8);
    pop1();

    // Accelerator busy at accept
    hold_low = 1'b1;
    s0 = start_cnt;
    send(16'h0030);
    for (int i = 0; i < 4; i++) begin
      chk("t5_arm_no_start", 32'(acc_start), 0);
      tick();
    end
    chk("t5_arm_busy", 32'(busy), 1);
    hold_low = 1'b0;
    wait_valid(40, n);
    chk("t5_starts", 32'(start_cnt - s0), 1);
    chk("t5_data", 32'(out_data), 32'hA595);
    chk("t5_jobs", 32'(job_count), 9);
    pop1();

    // Reset in WAIT_DONE with two results queued
    send(16'h0001);
    send(16'h0002);
    wait_jobs(8'd11, 100);
    mode = 2;
    send(16'h0003);
    repeat (8) tick();
    chk("t6_pre_busy", 32'(busy), 1);
    chk("t6_pre_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_jobs", 32'(job_count), 0);
    chk("t6_acc_start", 32'(acc_start), 0);
    chk("t6_busy", 32'(busy), 0);
    mode = 0;
    #2 rst = 1'b0;
    tick();
    chk("t6_in_ready", 32'(in_ready), 1);

    // acc_start drops as soon as reset asserts, without waiting for a clock
    send(16'h0044);
    tick();
    chk("t7_start_high", 32'(acc_start), 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_start_async", 32'(acc_start), 0);
    chk("t7_acc_x", 32'(acc_x), 0);
    #2 rst = 1'b0;
    tick();
    chk("t7_in_ready", 32'(in_ready), 1);

    chk("no_double_start", 32'(double_start), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
